// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the fill-bit helper used at the pipeline entry.
package barrel_shifter_pipe_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_op_t;

  // Bit shifted in from the top on right shifts: the operand sign for SRA, zero otherwise.
  function automatic logic fill_bit(input sh_op_t op, input logic msb);
    return (op == SH_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_stage.sv
// One logarithmic shifter stage: moves the word by DIST positions when enabled.
module shift_stage
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic             fill,
  input  logic             en,
  output logic [WIDTH-1:0] result
);

  // Select the shifted word for the requested mode, or pass through when disabled.
  always_comb begin
    result = data;
    if (en) begin
      case (sh_op_t'(op))
        SH_SLL:         result = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SH_SRL, SH_SRA: result = {{DIST{fill}}, data[WIDTH-1:DIST]};
        SH_ROR:         result = {data[DIST-1:0], data[WIDTH-1:DIST]};
        default:        result = data;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROR) with valid/ready
// flow control and a sideband tag. Stages run largest distance first; a
// register follows stage 2^k whenever REG_MASK[k] is set.
module barrel_shifter_pipe
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int unsigned        WIDTH    = 32,
  parameter int unsigned        SHAMT_W  = $clog2(WIDTH),
  parameter logic [SHAMT_W-1:0] REG_MASK = SHAMT_W'(1),
  parameter int unsigned        TAG_W    = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned LAT = $countones(REG_MASK);

  // Position j is the value entering the j-th stage (largest distance first).
  // Control fields are only needed by stages that still have to run.
  logic [WIDTH-1:0]   p_data  [SHAMT_W+1];
  logic [TAG_W-1:0]   p_tag   [SHAMT_W+1];
  logic               p_valid [SHAMT_W+1];
  sh_op_t             p_op    [SHAMT_W];
  logic               p_sign  [SHAMT_W];
  logic [SHAMT_W-1:0] p_shamt [SHAMT_W];
  logic [WIDTH-1:0]   s_data  [SHAMT_W];
  logic               adv;

  // A purely combinational build forwards downstream readiness directly.
  assign adv      = (LAT == 0) ? out_ready : (!out_valid || out_ready);
  assign in_ready = adv;

  assign p_data[0]  = in_data;
  assign p_tag[0]   = in_tag;
  assign p_valid[0] = in_valid;
  assign p_op[0]    = sh_op_t'(in_op);
  assign p_sign[0]  = fill_bit(sh_op_t'(in_op), in_data[WIDTH-1]);
  assign p_shamt[0] = in_shamt;

  for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
    localparam int unsigned K = SHAMT_W - 1 - j;

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << K)
    ) u_stage (
      .data   (p_data[j]),
      .op     (p_op[j]),
      .fill   (p_sign[j]),
      .en     (p_shamt[j][K]),
      .result (s_data[j])
    );

    if (REG_MASK[K]) begin : g_reg
      logic [WIDTH-1:0] r_data;
      logic [TAG_W-1:0] r_tag;
      logic             r_valid;

      // Valid follows the global advance; payload loads only behind a valid op so outputs hold across bubbles.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_tag   <= '0;
        end else if (adv) begin
          r_valid <= p_valid[j];
          if (p_valid[j]) begin
            r_data <= s_data[j];
            r_tag  <= p_tag[j];
          end
        end
      end

      assign p_data[j+1]  = r_data;
      assign p_tag[j+1]   = r_tag;
      assign p_valid[j+1] = r_valid;

      if (j + 1 < SHAMT_W) begin : g_ctl
        sh_op_t             r_op;
        logic               r_sign;
        logic [SHAMT_W-1:0] r_shamt;

        // Carry mode, fill bit and remaining shift bits alongside the data.
        always_ff @(posedge clock) begin
          if (reset) begin
            r_op    <= SH_SLL;
            r_sign  <= 1'b0;
            r_shamt <= '0;
          end else if (adv && p_valid[j]) begin
            r_op    <= p_op[j];
            r_sign  <= p_sign[j];
            r_shamt <= p_shamt[j];
          end
        end

        assign p_op[j+1]    = r_op;
        assign p_sign[j+1]  = r_sign;
        assign p_shamt[j+1] = r_shamt;
      end
    end else begin : g_comb
      assign p_data[j+1]  = s_data[j];
      assign p_tag[j+1]   = p_tag[j];
      assign p_valid[j+1] = p_valid[j];

      if (j + 1 < SHAMT_W) begin : g_ctl
        assign p_op[j+1]    = p_op[j];
        assign p_sign[j+1]  = p_sign[j];
        assign p_shamt[j+1] = p_shamt[j];
      end
    end
  end

  assign out_valid = p_valid[SHAMT_W];
  assign out_data  = p_data[SHAMT_W];
  assign out_tag   = p_tag[SHAMT_W];
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe: three 32-bit builds (LAT 0, 1, 3)
// share one input stream, plus an 8-bit smoke instance.
module tb_barrel_shifter_pipe;
  import barrel_shifter_pipe_pkg::*;

  localparam int unsigned NVEC = 12;
  localparam int unsigned CAP  = 64;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic [4:0]  tag;
    logic [31:0] cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared 32-bit stimulus
  logic        iv;
  logic [31:0] idata;
  logic [4:0]  ishamt;
  logic [1:0]  iop;
  logic [4:0]  itag;
  logic [31:0] cur_exp;

  logic        ir   [3];
  logic        ordy [3];
  logic        ov   [3];
  logic [31:0] od   [3];
  logic        oz   [3];
  logic [4:0]  ot   [3];
  int unsigned lat  [3] = '{0, 1, 3};

  // 8-bit instance
  logic       iv8, ir8, ov8, ordy8, oz8;
  logic [7:0] id8, od8;
  logic [2:0] ish8;
  logic [1:0] iop8;
  logic [4:0] it8, ot8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rec_t        exp_a [3][CAP];
  rec_t        got_a [3][CAP];
  int unsigned exp_n [3];
  int unsigned got_n [3];

  // directed vectors with hand-computed results
  logic [31:0] vdata  [NVEC] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                 32'h7000_0000, 32'h0000_0001, 32'h1234_5678, 32'h0000_0000,
                                 32'h1234_5678, 32'h8000_0001, 32'hDEAD_BEEF, 32'h8000_0000};
  logic [4:0]  vshamt [NVEC] = '{5'd31, 5'd4, 5'd31, 5'd4, 5'd4, 5'd1, 5'd0, 5'd0,
                                 5'd8, 5'd31, 5'd16, 5'd0};
  logic [1:0]  vop    [NVEC] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00,
                                 2'b11, 2'b10, 2'b01, 2'b10};
  logic [4:0]  vtag   [NVEC] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h1A,
                                 5'h08, 5'h09, 5'h0A, 5'h0B};
  logic [31:0] vexp   [NVEC] = '{32'h8000_0000, 32'hFFFF_FFF0, 32'h0000_0001, 32'hF800_0000,
                                 32'h0700_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_0000,
                                 32'h7812_3456, 32'hFFFF_FFFF, 32'h0000_DEAD, 32'h8000_0000};

  barrel_shifter_pipe #(.WIDTH(32), .REG_MASK(5'b00000)) u_lat0 (
    .clock(clk), .reset(rst), .in_valid(iv), .in_ready(ir[0]), .in_data(idata),
    .in_shamt(ishamt), .in_op(iop), .in_tag(itag), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_zero(oz[0]), .out_tag(ot[0]));

  barrel_shifter_pipe #(.WIDTH(32)) u_lat1 (
    .clock(clk), .reset(rst), .in_valid(iv), .in_ready(ir[1]), .in_data(idata),
    .in_shamt(ishamt), .in_op(iop), .in_tag(itag), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_zero(oz[1]), .out_tag(ot[1]));

  barrel_shifter_pipe #(.WIDTH(32), .REG_MASK(5'b10101)) u_lat3 (
    .clock(clk), .reset(rst), .in_valid(iv), .in_ready(ir[2]), .in_data(idata),
    .in_shamt(ishamt), .in_op(iop), .in_tag(itag), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od[2]), .out_zero(oz[2]), .out_tag(ot[2]));

  barrel_shifter_pipe #(.WIDTH(8)) u_w8 (
    .clock(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .in_shamt(ish8), .in_op(iop8), .in_tag(it8), .out_valid(ov8), .out_ready(ordy8),
    .out_data(od8), .out_zero(oz8), .out_tag(ot8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record accepted inputs and delivered outputs per instance, away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (iv && ir[d] && exp_n[d] < CAP) begin
          exp_a[d][exp_n[d]] = '{data: cur_exp, zero: (cur_exp == 32'h0), tag: itag, cyc: cyc};
          exp_n[d]++;
        end
        if (ov[d] && ordy[d] && got_n[d] < CAP) begin
          got_a[d][got_n[d]] = '{data: od[d], zero: oz[d], tag: ot[d], cyc: cyc};
          got_n[d]++;
        end
      end
    end
  end

  task automatic clear_logs();
    for (int d = 0; d < 3; d++) begin
      exp_n[d] = 0;
      got_n[d] = 0;
    end
  endtask

  task automatic drive(input int unsigned i);
    idata   = vdata[i];
    ishamt  = vshamt[i];
    iop     = vop[i];
    itag    = vtag[i];
    cur_exp = vexp[i];
    iv      = 1'b1;
  endtask

  task automatic compare_dut(input int d, input string ph, input int unsigned exp_count,
                             input bit lat_chk, input bit seq_chk);
    int unsigned n;
    check($sformatf("%s_count_d%0d", ph, d), 64'(got_n[d]), 64'(exp_count));
    n = (got_n[d] < exp_n[d]) ? got_n[d] : exp_n[d];
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_data_d%0d_%0d", ph, d, i), 64'(got_a[d][i].data), 64'(exp_a[d][i].data));
      check($sformatf("%s_tag_d%0d_%0d", ph, d, i), 64'(got_a[d][i].tag), 64'(exp_a[d][i].tag));
      check($sformatf("%s_zero_d%0d_%0d", ph, d, i), 64'(got_a[d][i].zero), 64'(exp_a[d][i].zero));
      if (lat_chk)
        check($sformatf("%s_lat_d%0d_%0d", ph, d, i),
              64'(got_a[d][i].cyc - exp_a[d][i].cyc), 64'(lat[d]));
      if (seq_chk && i > 0)
        check($sformatf("%s_seq_d%0d_%0d", ph, d, i),
              64'(got_a[d][i].cyc), 64'(got_a[d][i-1].cyc + 1));
    end
  endtask

  task automatic check_reset_outputs(input string ph, input int d);
    check($sformatf("%s_ov_d%0d", ph, d), 64'(ov[d]), 64'(0));
    check($sformatf("%s_od_d%0d", ph, d), 64'(od[d]), 64'(0));
    check($sformatf("%s_oz_d%0d", ph, d), 64'(oz[d]), 64'(1));
    check($sformatf("%s_ot_d%0d", ph, d), 64'(ot[d]), 64'(0));
    check($sformatf("%s_ir_d%0d", ph, d), 64'(ir[d]), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    int unsigned idx;
    logic [31:0] held_d;
    logic [4:0]  held_t;
    logic [7:0]  d8  [4] = '{8'h80, 8'h01, 8'h01, 8'h80};
    logic [2:0]  s8  [4] = '{3'd7, 3'd7, 3'd3, 3'd7};
    logic [1:0]  o8  [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    logic [7:0]  e8  [4] = '{8'hFF, 8'h80, 8'h20, 8'h01};

    rst = 1'b1; iv = 1'b0; idata = '0; ishamt = '0; iop = '0; itag = '0; cur_exp = '0;
    for (int d = 0; d < 3; d++) ordy[d] = 1'b1;
    iv8 = 1'b0; id8 = '0; ish8 = '0; iop8 = '0; it8 = '0; ordy8 = 1'b1;
    clear_logs();

    // reset state on the cycle after reset asserts
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("A", 1);
    check_reset_outputs("A", 2);
    check("A_ov_d0", 64'(ov[0]), 64'(0));
    check("A_ir_d0", 64'(ir[0]), 64'(1));
    check("A_ov8", 64'(ov8), 64'(0));
    check("A_oz8", 64'(oz8), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back directed vectors with out_ready held high
    clear_logs();
    for (int unsigned i = 0; i < NVEC; i++) begin
      drive(i);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) compare_dut(d, "B", NVEC, 1'b1, 1'b1);

    // backpressure on the LAT=3 build for five cycles while streaming
    clear_logs();
    t = 0; idx = 0; held_d = '0; held_t = '0;
    while ((idx < NVEC || got_n[2] < NVEC) && t < 200) begin
      ordy[2] = !(t >= 4 && t < 9);
      if (idx < NVEC) drive(idx);
      else iv = 1'b0;
      @(negedge clk);
      if (t == 4) begin
        held_d = od[2];
        held_t = ot[2];
        check("C_stall_first_data", 64'(od[2]), 64'(vexp[1]));
      end
      if (t >= 4 && t < 9) begin
        check($sformatf("C_stall_ir_%0d", t), 64'(ir[2]), 64'(0));
        check($sformatf("C_stall_ov_%0d", t), 64'(ov[2]), 64'(1));
        check($sformatf("C_stall_od_%0d", t), 64'(od[2]), 64'(held_d));
        check($sformatf("C_stall_ot_%0d", t), 64'(ot[2]), 64'(held_t));
      end
      if (iv && ir[2]) idx++;
      @(posedge clk); #1;
      t++;
    end
    iv = 1'b0;
    ordy[2] = 1'b1;
    check("C_timeout", 64'(t < 200), 64'(1));
    check("C_count_d2", 64'(got_n[2]), 64'(NVEC));
    for (int unsigned i = 0; i < NVEC && i < got_n[2]; i++) begin
      check($sformatf("C_data_d2_%0d", i), 64'(got_a[2][i].data), 64'(vexp[i]));
      check($sformatf("C_tag_d2_%0d", i), 64'(got_a[2][i].tag), 64'(vtag[i]));
    end
    repeat (3) @(posedge clk);
    #1;
    compare_dut(0, "C", exp_n[0], 1'b1, 1'b0);
    compare_dut(1, "C", exp_n[1], 1'b1, 1'b0);

    // reset with three ops in flight on the LAT=3 build (held by out_ready=0)
    clear_logs();
    ordy[2] = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(i);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    @(negedge clk);
    check("D_full_ov", 64'(ov[2]), 64'(1));
    check("D_full_ir", 64'(ir[2]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    drive(5);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("D", 2);
    @(posedge clk); #1;
    iv = 1'b0;
    rst = 1'b0;
    ordy[2] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("D_none_emitted", 64'(got_n[2]), 64'(0));
    check("D_idle_ov", 64'(ov[2]), 64'(0));

    // WIDTH=8 smoke
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      id8 = d8[i]; ish8 = s8[i]; iop8 = o8[i]; it8 = 5'(i + 3); iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(negedge clk);
      check($sformatf("E_ov8_%0d", i), 64'(ov8), 64'(1));
      check($sformatf("E_od8_%0d", i), 64'(od8), 64'(e8[i]));
      check($sformatf("E_ot8_%0d", i), 64'(ot8), 64'(i + 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
